// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write counters for the decode stage.
// Counts in-flight writes from issue until writeback or annul, raises the
// combinational ID stall on RAW and WAW-capacity conflicts, keeps a
// saturating stall-cycle statistic and a sticky protocol-error flag.
module reg_scoreboard #(
    parameter int CNT_W   = 2,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         src1,
    input  logic               src1_valid,
    input  logic [3:0]         src2,
    input  logic               two_src,
    input  logic               issue_en,
    input  logic [3:0]         issue_dest,
    input  logic               kill_en,
    input  logic [3:0]         kill_dest,
    input  logic               wb_en,
    input  logic [3:0]         wb_dest,
    output logic               hazard,
    output logic [15:0]        pending_mask,
    output logic [STALL_W-1:0] stall_cycles,
    output logic               err
);

    localparam int NREG = 16;
    // Largest count a register may hold; also the WAW-capacity limit.
    localparam logic [CNT_W-1:0] MAXC = '1;

    logic [CNT_W-1:0]   cnt_q [NREG];
    logic [CNT_W-1:0]   cnt_d [NREG];
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               err_q, err_d;

    logic src1_busy, src2_busy, issue_dest_full;

    // A register is busy for ID when its count, minus a same-cycle retire, is
    // still non-zero; the register file writes before decode reads it.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        src1_busy       = 1'b0;
        src2_busy       = 1'b0;
        issue_dest_full = 1'b0;
        if (cnt_q[src1] > CNT_W'(1) ||
            (cnt_q[src1] == CNT_W'(1) && !(wb_en && wb_dest == src1))) begin
            src1_busy = 1'b1;
        end
        if (cnt_q[src2] > CNT_W'(1) ||
            (cnt_q[src2] == CNT_W'(1) && !(wb_en && wb_dest == src2))) begin
            src2_busy = 1'b1;
        end
        if (issue_en && cnt_q[issue_dest] == MAXC) begin
            issue_dest_full = 1'b1;
        end
        hazard = (src1_valid & src1_busy) | (two_src & src2_busy) | issue_dest_full;
    end

    // Next count per register with clamping; any clamp or an issue during a
    // stall marks a protocol error. Also advances the stall statistic.
    always_comb begin
        err_d   = err_q;
        stall_d = stall_q;
        for (int r = 0; r < NREG; r++) begin : next_cnt
            logic                   inc, wb_hit, kill_hit;
            logic signed [CNT_W+1:0] sum;
            inc      = issue_en && (issue_dest == 4'(r));
            wb_hit   = wb_en    && (wb_dest    == 4'(r));
            kill_hit = kill_en  && (kill_dest  == 4'(r));
            sum = $signed({2'b00, cnt_q[r]})
                + $signed({{(CNT_W+1){1'b0}}, inc})
                - $signed({{(CNT_W+1){1'b0}}, wb_hit})
                - $signed({{(CNT_W+1){1'b0}}, kill_hit});
            cnt_d[r] = sum[CNT_W-1:0];
            if (sum < 0) begin
                cnt_d[r] = '0;
                err_d    = 1'b1;
            end else if (sum > $signed({2'b00, MAXC})) begin
                cnt_d[r] = MAXC;
                err_d    = 1'b1;
            end
        end
        if (issue_en && hazard) begin
            err_d = 1'b1;
        end
        if (hazard && stall_q != '1) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    // State registers; reset discards every pending write immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the counter array is reset with the rest of the state
            // because a stale count would stall decode forever after reset.
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // computed before this edge, independent of statement order.
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    // Occupancy view straight from the counter flops.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            pending_mask[r] = (cnt_q[r] != '0);
        end
    end

    assign stall_cycles = stall_q;
    assign err          = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed walk through the scoreboard's main scenarios
// followed by a randomized phase, all compared against a behavioural model
// of pending-write counts kept as plain integers.
module tb_reg_scoreboard;

    localparam int MAXC = 3;
    localparam int SMAX = 65535;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  src1 = '0, src2 = '0, issue_dest = '0, kill_dest = '0, wb_dest = '0;
    logic        src1_valid = 1'b0, two_src = 1'b0, issue_en = 1'b0;
    logic        kill_en = 1'b0, wb_en = 1'b0;
    logic        hazard, err;
    logic [15:0] pending_mask, stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    int m_cnt [16];
    int m_stall;
    bit m_err;

    reg_scoreboard #(.CNT_W(2), .STALL_W(16)) dut (
        .clk(clk), .rst(rst),
        .src1(src1), .src1_valid(src1_valid),
        .src2(src2), .two_src(two_src),
        .issue_en(issue_en), .issue_dest(issue_dest),
        .kill_en(kill_en), .kill_dest(kill_dest),
        .wb_en(wb_en), .wb_dest(wb_dest),
        .hazard(hazard), .pending_mask(pending_mask),
        .stall_cycles(stall_cycles), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        foreach (m_cnt[r]) m_cnt[r] = 0;
        m_stall = 0;
        m_err   = 1'b0;
    endfunction

    function automatic int eff(input logic [3:0] r);
        int e;
        e = m_cnt[r] - ((wb_en && wb_dest == r) ? 1 : 0);
        return (e < 0) ? 0 : e;
    endfunction

    function automatic bit model_hazard();
        return (src1_valid && eff(src1) != 0) || (two_src && eff(src2) != 0) ||
               (issue_en && m_cnt[issue_dest] == MAXC);
    endfunction

    function automatic logic [15:0] model_mask();
        logic [15:0] m;
        for (int r = 0; r < 16; r++) m[r] = (m_cnt[r] != 0);
        return m;
    endfunction

    // Settle, compare every output with the model, then clock one edge and
    // advance the model with the inputs that were applied.
    task automatic tick();
        bit h;
        #2;
        h = model_hazard();
        check("hazard", 32'(hazard), 32'(h));
        check("pending_mask", 32'(pending_mask), 32'(model_mask()));
        check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        check("err", 32'(err), 32'(m_err));
        @(posedge clk);
        for (int r = 0; r < 16; r++) begin
            int n;
            n = m_cnt[r] + ((issue_en && issue_dest == r) ? 1 : 0)
                         - ((wb_en && wb_dest == r) ? 1 : 0)
                         - ((kill_en && kill_dest == r) ? 1 : 0);
            if (n < 0) begin n = 0; m_err = 1'b1; end
            if (n > MAXC) begin n = MAXC; m_err = 1'b1; end
            m_cnt[r] = n;
        end
        if (issue_en && h) m_err = 1'b1;
        if (h && m_stall < SMAX) m_stall++;
        #1;
    endtask

    task automatic idle_inputs();
        src1_valid = 1'b0; two_src = 1'b0; issue_en = 1'b0;
        kill_en = 1'b0; wb_en = 1'b0;
    endtask

    initial begin
        model_reset();
        // Reset, then idle with a live read of R3.
        src1 = 4'd3; src1_valid = 1'b1;
        #3;
        check("rst_hazard", 32'(hazard), 32'd0);
        check("rst_mask", 32'(pending_mask), 32'h0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        check("idle_mask", 32'(pending_mask), 32'h0);

        // Issue R5, stall two cycles on it, retire with same-cycle bypass.
        idle_inputs();
        issue_en = 1'b1; issue_dest = 4'd5;
        tick();
        idle_inputs();
        src1 = 4'd5; src1_valid = 1'b1;
        #1;
        check("raw_hazard", 32'(hazard), 32'd1);
        check("raw_mask", 32'(pending_mask), 32'h0020);
        tick();
        tick();
        wb_en = 1'b1; wb_dest = 4'd5;
        #1;
        check("bypass_hazard", 32'(hazard), 32'd0);
        tick();
        idle_inputs();
        #1;
        check("retire_mask", 32'(pending_mask), 32'h0);
        check("stall_two", 32'(stall_cycles), 32'd2);

        // Fill R2 to capacity, probe the WAW-capacity stall without clocking it.
        idle_inputs();
        src2 = 4'd2;
        issue_en = 1'b1; issue_dest = 4'd2;
        for (int i = 0; i < 3; i++) tick();
        #1;
        check("full_hazard", 32'(hazard), 32'd1);
        issue_en = 1'b0;
        #1;
        check("full_released", 32'(hazard), 32'd0);
        wb_en = 1'b1; wb_dest = 4'd2;
        tick();
        issue_en = 1'b1;
        tick();
        // Count should be 2: first retire still leaves one pending.
        issue_en = 1'b0; two_src = 1'b1;
        #1;
        check("cnt2_after_retire", 32'(hazard), 32'd1);
        tick();
        check("cnt1_mask", 32'(pending_mask), 32'h0004);
        tick();
        idle_inputs();
        #1;
        check("r2_drained", 32'(pending_mask), 32'h0);
        check("no_err_yet", 32'(err), 32'd0);

        // Issue R7 and annul it in EXE.
        issue_en = 1'b1; issue_dest = 4'd7;
        tick();
        idle_inputs();
        kill_en = 1'b1; kill_dest = 4'd7;
        #1;
        check("kill_mask_before", 32'(pending_mask), 32'h0080);
        tick();
        idle_inputs();
        #1;
        check("kill_mask_after", 32'(pending_mask), 32'h0);
        check("kill_err", 32'(err), 32'd0);

        // Retire a register with nothing pending: sticky underflow error.
        wb_en = 1'b1; wb_dest = 4'd9;
        tick();
        idle_inputs();
        tick();
        tick();
        check("underflow_err", 32'(err), 32'd1);
        check("underflow_mask", 32'(pending_mask), 32'h0);

        // Asynchronous reset mid-cycle with two writes pending on R4.
        issue_en = 1'b1; issue_dest = 4'd4;
        tick();
        tick();
        idle_inputs();
        src1 = 4'd4; src1_valid = 1'b1;
        #1;
        check("r4_busy", 32'(hazard), 32'd1);
        rst = 1'b1;
        #1;
        check("async_mask", 32'(pending_mask), 32'h0);
        check("async_hazard", 32'(hazard), 32'd0);
        check("async_err", 32'(err), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;

        // Randomized traffic on a narrow register window for frequent collisions.
        for (int i = 0; i < 600; i++) begin
            src1       = 4'($urandom_range(0, 5));
            src2       = 4'($urandom_range(0, 5));
            src1_valid = 1'($urandom);
            two_src    = 1'($urandom);
            issue_dest = 4'($urandom_range(0, 5));
            wb_dest    = 4'($urandom_range(0, 5));
            kill_dest  = 4'($urandom_range(0, 5));
            wb_en      = ($urandom_range(0, 99) < 40);
            kill_en    = ($urandom_range(0, 99) < 10);
            issue_en   = ($urandom_range(0, 99) < 55);
            // Mostly honour the stall protocol so counters build up.
            #1;
            if (model_hazard() && $urandom_range(0, 9) != 0) issue_en = 1'b0;
            #0;
            tick();
        end
        idle_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
